// File: rtl/button_event_decoder.sv
// Button gesture decoder.
// Turns a debounced, clock-synchronous button level into one-cycle event
// pulses: raw press/release edges plus the higher-level gestures short click,
// double click and long press. A single 32-bit cycle counter times both the
// hold duration and the release-to-second-press gap; it restarts on every
// state change, so its value always measures time spent in the current state.

module button_event_decoder #(
    parameter logic [31:0] LONG_CYCLES = 32'd50_000_000,
    parameter logic [31:0] GAP_CYCLES  = 32'd12_500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_button,
    output logic o_press,
    output logic o_release,
    output logic o_short_click,
    output logic o_double_click,
    output logic o_long_press,
    output logic o_held
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } state_t;

    // The counter reads N-1 on the Nth cycle spent in a state, so the
    // thresholds are compared one below the nominal cycle counts.
    localparam logic [31:0] LONG_LAST = LONG_CYCLES - 32'd1;
    localparam logic [31:0] GAP_LAST  = GAP_CYCLES - 32'd1;

    state_t      state_q;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        btnPrev_q;
    logic        press_q;
    logic        release_q;
    logic        shortClick_q;
    logic        doubleClick_q;
    logic        longPress_q;

    logic        rise;
    logic        fall;
    logic        longReached;
    logic        gapReached;

    // Edges are judged on the live input against last cycle's level.
    assign rise        = i_button & ~btnPrev_q;
    assign fall        = ~i_button & btnPrev_q;
    assign longReached = (count_q == LONG_LAST);
    assign gapReached  = (count_q == GAP_LAST);

    // Saturating increment: a button left alone for ages must not wrap the
    // counter around into a false threshold match.
    assign count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

    // Level history plus registered raw edge pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btnPrev_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            btnPrev_q <= i_button;
            press_q   <= rise;
            release_q <= fall;
        end
    end

    // Gesture FSM with the shared cycle counter and registered gesture pulses.
    // Edges are checked before timeouts so a release (or second press)
    // landing on the very threshold cycle wins over the timeout event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            count_q       <= 32'd0;
            shortClick_q  <= 1'b0;
            doubleClick_q <= 1'b0;
            longPress_q   <= 1'b0;
        end else begin
            shortClick_q  <= 1'b0;
            doubleClick_q <= 1'b0;
            longPress_q   <= 1'b0;
            count_q       <= count_d;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= PRESSED;
                        count_q <= 32'd0;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        state_q <= WAIT_SECOND;
                        count_q <= 32'd0;
                    end else if (longReached) begin
                        longPress_q <= 1'b1;
                        state_q     <= LONG_HELD;
                        count_q     <= 32'd0;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state_q <= IDLE;
                        count_q <= 32'd0;
                    end
                end
                WAIT_SECOND: begin
                    if (rise) begin
                        state_q <= SECOND_PRESSED;
                        count_q <= 32'd0;
                    end else if (gapReached) begin
                        shortClick_q <= 1'b1;
                        state_q      <= IDLE;
                        count_q      <= 32'd0;
                    end
                end
                SECOND_PRESSED: begin
                    if (fall) begin
                        doubleClick_q <= 1'b1;
                        state_q       <= IDLE;
                        count_q       <= 32'd0;
                    end else if (longReached) begin
                        longPress_q <= 1'b1;
                        state_q     <= LONG_HELD;
                        count_q     <= 32'd0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= 32'd0;
                end
            endcase
        end
    end

    assign o_press        = press_q;
    assign o_release      = release_q;
    assign o_short_click  = shortClick_q;
    assign o_double_click = doubleClick_q;
    assign o_long_press   = longPress_q;
    assign o_held         = btnPrev_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder with LONG_CYCLES=10, GAP_CYCLES=5.
// Stimulus is described as alternating runs of pressed/released cycles; a
// gesture-level model turns run lengths into expected per-cycle event words.

module tb_button_event_decoder;

    localparam int LONG = 10;
    localparam int GAP  = 5;

    // Event word layout: {held, double, long, short, release, press}
    localparam logic [5:0] EV_PRESS   = 6'b000001;
    localparam logic [5:0] EV_RELEASE = 6'b000010;
    localparam logic [5:0] EV_SHORT   = 6'b000100;
    localparam logic [5:0] EV_LONG    = 6'b001000;
    localparam logic [5:0] EV_DOUBLE  = 6'b010000;
    localparam logic [5:0] EV_HELD    = 6'b100000;

    logic clk;
    logic rstN;
    logic buttonIn;
    logic oPress, oRelease, oShort, oDouble, oLong, oHeld;

    logic [5:0] observed;
    int         total;
    int         bad;

    int         runLen[$];
    logic       lvlQ[$];
    logic [5:0] expQ[$];

    button_event_decoder #(
        .LONG_CYCLES(32'd10),
        .GAP_CYCLES (32'd5)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_button      (buttonIn),
        .o_press       (oPress),
        .o_release     (oRelease),
        .o_short_click (oShort),
        .o_double_click(oDouble),
        .o_long_press  (oLong),
        .o_held        (oHeld)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Current DUT outputs packed into an event word.
    task automatic sampleOutputs();
        observed = {oHeld, oDouble, oLong, oShort, oRelease, oPress};
    endtask

    // Drive one button level for one cycle and capture the outputs after the edge.
    task automatic applyStimulus(input logic lvl);
        @(negedge clk);
        buttonIn = lvl;
        @(posedge clk);
        #1;
        sampleOutputs();
    endtask

    task automatic addRun(input int n);
        runLen.push_back(n);
    endtask

    // Gesture model. Even-numbered runs are pressed, odd ones released; the
    // level before the first run is released. A hold of LONG+1 or more
    // samples is a long press reported LONG samples after the press; a
    // release gap of GAP+1 or more samples confirms a short click GAP samples
    // after the release; otherwise the next press is a second click and its
    // release yields a double click.
    task automatic buildModel();
        logic       prevLvl;
        logic       lvl;
        logic [5:0] ev;
        int         t;
        int         n;
        bit         pending;
        lvlQ.delete();
        expQ.delete();
        prevLvl = 1'b0;
        for (int r = 0; r < runLen.size(); r++) begin
            lvl = (r % 2 == 0);
            for (int k = 0; k < runLen[r]; k++) begin
                ev = lvl ? EV_HELD : 6'b0;
                if (lvl && !prevLvl) ev = ev | EV_PRESS;
                if (!lvl && prevLvl) ev = ev | EV_RELEASE;
                lvlQ.push_back(lvl);
                expQ.push_back(ev);
                prevLvl = lvl;
            end
        end
        t = 0;
        pending = 1'b0;
        for (int r = 0; r < runLen.size(); r++) begin
            n = runLen[r];
            if (r % 2 == 0) begin
                if (n >= LONG + 1) begin
                    expQ[t + LONG] = expQ[t + LONG] | EV_LONG;
                    pending = 1'b0;
                end else if (pending) begin
                    expQ[t + n] = expQ[t + n] | EV_DOUBLE;
                    pending = 1'b0;
                end else begin
                    pending = 1'b1;
                end
            end else begin
                if (pending && n >= GAP + 1) begin
                    expQ[t + GAP] = expQ[t + GAP] | EV_SHORT;
                    pending = 1'b0;
                end
            end
            t = t + n;
        end
    endtask

    // Outputs must be zero while reset is held, whatever the button does.
    task automatic test_reset();
        rstN = 1'b0;
        buttonIn = 1'b0;
        #1;
        sampleOutputs();
        total++;
        if (observed !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_initial: got %b want %b", observed, 6'b0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            buttonIn = i[0];
            @(posedge clk);
            #1;
            sampleOutputs();
            total++;
            if (observed !== 6'b0) begin
                bad++;
                $display("[TB] FAIL reset_hold cycle %0d: got %b want %b", i, observed, 6'b0);
            end
        end
        @(negedge clk);
        buttonIn = 1'b0;
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0);
            total++;
            if (observed !== 6'b0) begin
                bad++;
                $display("[TB] FAIL reset_idle cycle %0d: got %b want %b", i, observed, 6'b0);
            end
        end
    endtask

    // Single click, double click, and long press with their nominal timing.
    task automatic test_basic_gestures();
        runLen.delete();
        addRun(3);  addRun(12);
        addRun(3);  addRun(2);  addRun(3);  addRun(12);
        addRun(15); addRun(12);
        buildModel();
        foreach (expQ[i]) begin
            applyStimulus(lvlQ[i]);
            total++;
            if (observed !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL basic_gestures cycle %0d: got %b want %b", i, observed, expQ[i]);
            end
        end
    endtask

    // Threshold cycles: gap of exactly GAP vs GAP+1, hold of exactly LONG vs LONG+1.
    task automatic test_boundaries();
        runLen.delete();
        addRun(3);  addRun(5);  addRun(3);  addRun(12);
        addRun(3);  addRun(6);  addRun(3);  addRun(12);
        addRun(10); addRun(12);
        addRun(11); addRun(12);
        addRun(2);  addRun(1);  addRun(10); addRun(12);
        addRun(2);  addRun(1);  addRun(11); addRun(12);
        buildModel();
        foreach (expQ[i]) begin
            applyStimulus(lvlQ[i]);
            total++;
            if (observed !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL boundaries cycle %0d: got %b want %b", i, observed, expQ[i]);
            end
        end
    endtask

    // Third press straight after a double click starts a fresh gesture.
    task automatic test_back_to_back();
        runLen.delete();
        addRun(2); addRun(2); addRun(2); addRun(1); addRun(2); addRun(12);
        addRun(1); addRun(1); addRun(1); addRun(1); addRun(1); addRun(1);
        addRun(1); addRun(12);
        buildModel();
        foreach (expQ[i]) begin
            applyStimulus(lvlQ[i]);
            total++;
            if (observed !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b want %b", i, observed, expQ[i]);
            end
        end
    endtask

    // Random hold and gap lengths straddling both thresholds.
    task automatic test_random();
        for (int iter = 0; iter < 6; iter++) begin
            runLen.delete();
            for (int g = 0; g < 8; g++) begin
                addRun(int'($urandom_range(1, 13)));
                addRun(int'($urandom_range(1, 8)));
            end
            addRun(int'($urandom_range(1, 13)));
            addRun(12);
            buildModel();
            foreach (expQ[i]) begin
                applyStimulus(lvlQ[i]);
                total++;
                if (observed !== expQ[i]) begin
                    bad++;
                    $display("[TB] FAIL random iter %0d cycle %0d: got %b want %b",
                             iter, i, observed, expQ[i]);
                end
            end
        end
    endtask

    // Reset during the wait for a second press drops the pending short click.
    task automatic test_reset_mid_gesture();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0);
        @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        sampleOutputs();
        total++;
        if (observed !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_async: got %b want %b", observed, 6'b0);
        end
        @(posedge clk);
        #3;
        rstN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0);
            total++;
            if (observed !== 6'b0) begin
                bad++;
                $display("[TB] FAIL reset_abort cycle %0d: got %b want %b", i, observed, 6'b0);
            end
        end
    endtask

    // Button held through reset release counts as a fresh press.
    task automatic test_reset_held_button();
        @(negedge clk);
        buttonIn = 1'b1;
        rstN = 1'b0;
        @(posedge clk);
        #1;
        sampleOutputs();
        total++;
        if (observed !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_button_high: got %b want %b", observed, 6'b0);
        end
        #3;
        rstN = 1'b1;
        runLen.delete();
        addRun(13); addRun(12);
        buildModel();
        foreach (expQ[i]) begin
            applyStimulus(lvlQ[i]);
            total++;
            if (observed !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL reset_held cycle %0d: got %b want %b", i, observed, expQ[i]);
            end
        end
    endtask

    // Run every scenario in order and report.
    initial begin
        total = 0;
        bad = 0;
        rstN = 1'b0;
        buttonIn = 1'b0;
        test_reset();
        test_basic_gestures();
        test_boundaries();
        test_back_to_back();
        test_random();
        test_reset_mid_gesture();
        test_reset_held_button();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 50_000_000, hold time for a long press (1 s at 50 MHz), legal range 2..2^32-1.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 12_500_000, maximum release-to-second-press gap for a double click (250 ms), legal range 2..2^32-1.
REQ-003 The block SHALL have port i_clk  input  1  50 MHz clock, all logic rising-edge.
REQ-004 The block SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port i_button  input  1  debounced, clock-synchronous button level (1 = pressed).
REQ-006 The block SHALL have port o_press  output  1  one-cycle pulse on each press edge.
REQ-007 The block SHALL have port o_release  output  1  one-cycle pulse on each release edge.
REQ-008 The block SHALL have port o_short_click  output  1  one-cycle pulse for a confirmed single short click.
REQ-009 The block SHALL have port o_double_click  output  1  one-cycle pulse for a confirmed double click.
REQ-010 The block SHALL have port o_long_press  output  1  one-cycle pulse when a hold reaches LONG_CYCLES.
REQ-011 The block SHALL have port o_held  output  1  registered copy of i_button.

Function
REQ-012 The block SHALL register i_button into btn_prev each cycle; rise = i_button & ~btn_prev, fall = ~i_button & btn_prev, evaluated on the current i_button.
REQ-013 All outputs SHALL be registered; o_press/o_release assert for exactly one cycle, in the cycle after the edge is sampled.
REQ-014 The block SHALL use one 32-bit cycle counter, cleared on every state transition, incremented otherwise, saturating at all-ones.
REQ-015 The FSM SHALL have states IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED.
REQ-016 IDLE: rise -> PRESSED; otherwise stay.
REQ-017 PRESSED: fall before count reaches LONG_CYCLES-1 -> WAIT_SECOND; count == LONG_CYCLES-1 with button still high -> pulse o_long_press, go LONG_HELD.
REQ-018 LONG_HELD: fall -> IDLE; no click pulse generated.
REQ-019 WAIT_SECOND: rise -> SECOND_PRESSED; count == GAP_CYCLES-1 without rise -> pulse o_short_click, go IDLE.
REQ-020 WAIT_SECOND: rise in the same cycle count reaches GAP_CYCLES-1 SHALL be treated as a second press (no o_short_click).
REQ-021 SECOND_PRESSED: fall before LONG_CYCLES-1 -> pulse o_double_click, go IDLE; reaching LONG_CYCLES-1 held -> pulse o_long_press (no double click), go LONG_HELD.
REQ-022 In PRESSED/SECOND_PRESSED, fall in the same cycle count reaches LONG_CYCLES-1 SHALL be treated as a release (no o_long_press).
REQ-023 At most one of o_short_click, o_double_click, o_long_press SHALL be high in any cycle; each gesture produces at most one of them.
REQ-024 A third press after o_double_click SHALL start a new gesture from IDLE.
REQ-025 Event pulse latency: o_short_click GAP_CYCLES cycles after the release edge; o_long_press LONG_CYCLES cycles after the press edge; o_double_click one cycle after the second release edge.

Reset
REQ-026 While i_rst_n = 0: FSM = IDLE, counter = 0, btn_prev = 0, all outputs = 0, regardless of clock.
REQ-027 Reset asserted mid-gesture SHALL abort it with no pending pulse emitted after release.
REQ-028 If i_button = 1 in the first cycle after reset release, it SHALL be treated as a press edge (o_press pulses, FSM -> PRESSED).

Verification (LONG_CYCLES=10, GAP_CYCLES=5)
REQ-029 Press 3 cycles, release, idle 10 -> o_press, o_release one pulse each; o_short_click one pulse 5 cycles after release; no other events.
REQ-030 Press 3, release 2, press 3, release -> o_press x2, o_double_click one pulse after second release; o_short_click never.
REQ-031 Press held 15 cycles -> o_long_press one pulse 10 cycles after press edge; release -> o_release only, no click.
REQ-032 Release-to-second-press gap exactly 5 cycles (rise on expiry cycle) -> double click, no short click; gap 6 -> short click, then new gesture.
REQ-033 Assert i_rst_n = 0 asynchronously during WAIT_SECOND, release reset, idle 10 -> all outputs 0 immediately, no o_short_click.
REQ-034 Hold i_button = 1 through reset release -> o_press in first post-reset cycle; hold 10 -> o_long_press.
